data_output_register: RTL and testbench
=======================================

# data_output_register

Data output register (DOR) and write-cycle sequencer for the 6502 core: captures a byte from the internal data bus (DB) and presents it on the external data bus during a sequenced write cycle. It is the outbound counterpart of the input data latch. The input data latch samples the external bus into the core; this block drives the external bus from the core, and owns the R/W line and the data-output enable. It sits between the internal DB bus and the pad/bus-interface logic.

## Interface
- `SETUP_CYCLES`, 1: cycles with R/W low before data is driven (≥1).
- `DRIVE_CYCLES`, 2: cycles with the data strobe high (≥1).
- `HOLD_CYCLES`, 1: cycles data stays driven after the strobe falls (≥0).
- `clk`  in  1  single clock; all state changes on rising edge.
- `reset`  in  1  synchronous, active-high.
- `db_in`  in  8  internal DB bus value.
- `load`  in  1  capture `db_in` into DOR this edge.
- `write_start`  in  1  begin a write cycle; accepted only in IDLE.
- `data_out`  out  8  byte presented to external bus (valid while `data_oe`).
- `data_oe`  out  1  external data-bus output enable.
- `rw`  out  1  1 = read, 0 = write.
- `data_strobe`  out  1  write strobe (phi2-equivalent) to the memory side.
- `busy`  out  1  high in any state other than IDLE.
- `done`  out  1  one-cycle pulse on return to IDLE after a write.

## Operation
- Two 8-bit registers:
  - `dor` is the value being driven.
  - `shadow` is a pending load, with flag `shadow_valid`.
- `load` in IDLE or SETUP: `dor <= db_in`.
- `load` in DRIVE or HOLD: `shadow <= db_in`, `shadow_valid <= 1`. The driven data never changes mid-strobe.
- On the transition HOLD→IDLE (or DRIVE→IDLE when `HOLD_CYCLES`=0), if `shadow_valid`: `dor <= shadow`, `shadow_valid <= 0`.
- A later `load` overwrites `shadow`; last writer wins.
- FSM states: IDLE, SETUP, DRIVE, HOLD.
  - IDLE: if `write_start`, go to SETUP and load the counter with `SETUP_CYCLES-1`.
  - SETUP: `rw`=0, `data_oe`=0. When the counter reaches 0, go to DRIVE with `DRIVE_CYCLES-1`.
  - DRIVE: `rw`=0, `data_oe`=1, `data_strobe`=1. At 0, go to HOLD with `HOLD_CYCLES-1`, or to IDLE if `HOLD_CYCLES`=0.
  - HOLD: `rw`=0, `data_oe`=1, `data_strobe`=0. At 0, go to IDLE.
- `load` and `write_start` in the same IDLE cycle: DOR takes `db_in`, and that new value is the one written.
- `write_start` while `busy` is ignored: no queueing, no error flag.
- `data_out` always equals `dor`. The pad drives it only when `data_oe`=1.
- The counter is unsigned, `$clog2(max(SETUP,DRIVE,HOLD)+1)` bits wide, decrements toward 0, and never wraps.

## Timing
- Reset values: state IDLE, `dor`=0x00, `shadow`=0x00, `shadow_valid`=0, `data_out`=0x00, `data_oe`=0, `rw`=1, `data_strobe`=0, `busy`=0, `done`=0.
- Reset asserted mid-cycle: the next edge forces all reset values, and `data_oe` drops that same edge. No `done` pulse is issued and the pending shadow is discarded.
- All outputs are registered; no combinational path from inputs to outputs.
- Latency for `write_start` sampled at edge 0:
  - edge 0: `busy`=1, `rw`=0.
  - edge `SETUP_CYCLES`: `data_oe`=1, `data_strobe`=1.
  - strobe held for exactly `DRIVE_CYCLES` cycles.
  - `data_oe` held for `DRIVE_CYCLES+HOLD_CYCLES` cycles.
  - at edge `S+D+H`: `busy`=0, `rw`=1, `data_oe`=0, and `done`=1 for exactly one cycle.
- Total cycle length: `S+D+H` clocks. The earliest next `write_start` is the cycle `done` is high; the FSM is IDLE then, so the start is accepted.
- `rw` falls no later than `data_oe` rises and rises no earlier than `data_oe` falls. `data_out` is stable over the whole `data_oe` window.

## Structure
- Package `cpu6502_pkg`:
  - `dor_state_t` enum (IDLE, SETUP, DRIVE, HOLD).
  - `RW_READ`=1'b1 and `RW_WRITE`=1'b0 constants.
- One sub-module, `phase_counter`: a loadable down-counter with a `zero` flag, parameterised width. The FSM and register logic stay in `data_output_register`.

## Test plan
- Defaults (S=1, D=2, H=1): `load` 0xA5, then `write_start` → `rw` low 4 cycles, `data_oe` high 3 cycles, `data_strobe` high 2 cycles, `data_out`=0xA5 throughout, `done` pulses once, `rw` returns to 1.
- Same-cycle `load` 0x3C + `write_start` in IDLE → the written byte is 0x3C, not the previous DOR value.
- `load` 0x11 during DRIVE of a 0x22 write → `data_out` stays 0x22 through HOLD; `dor`=0x11 on IDLE entry; a following write drives 0x11.
- `write_start` pulsed during SETUP and during HOLD → ignored; exactly one `done`, and total `busy` length is 4 cycles.
- `reset` asserted during DRIVE → next edge `data_oe`=0, `rw`=1, `data_out`=0x00, `busy`=0, no `done`.
- H=0 build (S=2, D=1): `data_oe` and `data_strobe` both high for exactly 1 cycle, and `busy` lasts 3 cycles.

Source files
------------

// File: rtl/data_output_register_pkg.sv
// Shared types and constants for the 6502 data output register.
// Holds the write-sequencer state encoding and R/W line levels.
package cpu6502_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        DRIVE = 2'd2,
        HOLD  = 2'd3
    } dor_state_t;

    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

endpackage

// File: rtl/data_output_register_if.sv
// Core-side bundle of the data output register: DB capture, write request,
// and the external bus / R/W / strobe signals it drives.
interface data_output_register_if;

    logic [7:0] db_in;
    logic       load;
    logic       write_start;
    logic [7:0] data_out;
    logic       data_oe;
    logic       rw;
    logic       data_strobe;
    logic       busy;
    logic       done;

    modport master (
        output db_in, load, write_start,
        input  data_out, data_oe, rw, data_strobe, busy, done
    );

    modport slave (
        input  db_in, load, write_start,
        output data_out, data_oe, rw, data_strobe, busy, done
    );

endinterface

// File: rtl/data_output_register_phase_counter.sv
// Loadable down-counter that parks at zero; zero flag is decoded from the count.
// Latency: load or decrement visible one edge later. No backpressure.
module phase_counter #(
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic             zero
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - WIDTH'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/data_output_register.sv
// Data output register and write-cycle sequencer: drives DB onto the external bus.
// Latency: S+D+H clocks per write, all outputs registered. write_start while busy is dropped.
module data_output_register
    import cpu6502_pkg::*;
#(
    parameter int SETUP_CYCLES = 1,
    parameter int DRIVE_CYCLES = 2,
    parameter int HOLD_CYCLES  = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    data_output_register_if.slave  bus
);

    localparam int CW = $clog2(max3(SETUP_CYCLES, DRIVE_CYCLES, HOLD_CYCLES) + 1);
    localparam logic [CW-1:0] S_LD = CW'(SETUP_CYCLES - 1);
    localparam logic [CW-1:0] D_LD = CW'(DRIVE_CYCLES - 1);
    localparam logic [CW-1:0] H_LD = CW'((HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0);

    dor_state_t      state, state_nxt;
    logic            cnt_load;
    logic [CW-1:0]   cnt_val;
    logic            cnt_zero;

    logic [7:0]      dor, shadow;
    logic            shadow_valid;

    logic            rw_q, oe_q, strobe_q, busy_q, done_q;
    logic            rw_nxt, oe_nxt, strobe_nxt, busy_nxt, done_nxt;

    phase_counter #(.WIDTH(CW)) u_phase_counter (
        .clk      (clk),
        .reset    (reset),
        .load     (cnt_load),
        .load_val (cnt_val),
        .zero     (cnt_zero)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_load  = 1'b0;
        cnt_val   = '0;
        case (state)
            IDLE: begin
                if (bus.write_start) begin
                    state_nxt = SETUP;
                    cnt_load  = 1'b1;
                    cnt_val   = S_LD;
                end
            end
            SETUP: begin
                if (cnt_zero) begin
                    state_nxt = DRIVE;
                    cnt_load  = 1'b1;
                    cnt_val   = D_LD;
                end
            end
            DRIVE: begin
                if (cnt_zero) begin
                    if (HOLD_CYCLES == 0) begin
                        state_nxt = IDLE;
                    end else begin
                        state_nxt = HOLD;
                        cnt_load  = 1'b1;
                        cnt_val   = H_LD;
                    end
                end
            end
            HOLD: begin
                if (cnt_zero) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase

        // Outputs are decoded from the next state so they can be registered.
        rw_nxt     = (state_nxt == IDLE) ? RW_READ : RW_WRITE;
        oe_nxt     = (state_nxt == DRIVE) || (state_nxt == HOLD);
        strobe_nxt = (state_nxt == DRIVE);
        busy_nxt   = (state_nxt != IDLE);
        done_nxt   = (state != IDLE) && (state_nxt == IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            dor          <= 8'h00;
            shadow       <= 8'h00;
            shadow_valid <= 1'b0;
            rw_q         <= RW_READ;
            oe_q         <= 1'b0;
            strobe_q     <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            rw_q     <= rw_nxt;
            oe_q     <= oe_nxt;
            strobe_q <= strobe_nxt;
            busy_q   <= busy_nxt;
            done_q   <= done_nxt;

            // A load arriving on the final edge is the newest value, so it beats the shadow.
            if (done_nxt) begin
                if (bus.load) begin
                    dor <= bus.db_in;
                end else if (shadow_valid) begin
                    dor <= shadow;
                end
                shadow_valid <= 1'b0;
            end else if (bus.load) begin
                if ((state == IDLE) || (state == SETUP)) begin
                    dor <= bus.db_in;
                end else begin
                    shadow       <= bus.db_in;
                    shadow_valid <= 1'b1;
                end
            end
        end
    end

    assign bus.data_out    = dor;
    assign bus.data_oe     = oe_q;
    assign bus.rw          = rw_q;
    assign bus.data_strobe = strobe_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;

endmodule

// File: tb/tb_data_output_register.sv
// Directed bench for data_output_register: default build and an S=2/D=1/H=0 build.
module tb_data_output_register;

    logic clk = 1'b0;
    logic rst_a = 1'b1;
    logic rst_b = 1'b1;

    always #5 clk = ~clk;

    data_output_register_if ba ();
    data_output_register_if bb ();

    data_output_register dut_a (
        .clk   (clk),
        .reset (rst_a),
        .bus   (ba)
    );

    data_output_register #(
        .SETUP_CYCLES (2),
        .DRIVE_CYCLES (1),
        .HOLD_CYCLES  (0)
    ) dut_b (
        .clk   (clk),
        .reset (rst_b),
        .bus   (bb)
    );

    int checks = 0;
    int errors = 0;
    int n_rw, n_oe, n_st, n_busy, n_done, n_bad, n_order;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_counts();
        n_rw = 0; n_oe = 0; n_st = 0; n_busy = 0; n_done = 0; n_bad = 0; n_order = 0;
    endtask

    task automatic sample(input int sel, input logic [7:0] exp_d);
        logic       rw_s, oe_s, st_s, busy_s, done_s;
        logic [7:0] d_s;
        if (sel == 0) begin
            rw_s = ba.rw; oe_s = ba.data_oe; st_s = ba.data_strobe;
            busy_s = ba.busy; done_s = ba.done; d_s = ba.data_out;
        end else begin
            rw_s = bb.rw; oe_s = bb.data_oe; st_s = bb.data_strobe;
            busy_s = bb.busy; done_s = bb.done; d_s = bb.data_out;
        end
        if (rw_s === 1'b0) n_rw++;
        if (oe_s === 1'b1) n_oe++;
        if (st_s === 1'b1) n_st++;
        if (busy_s === 1'b1) n_busy++;
        if (done_s === 1'b1) n_done++;
        if ((oe_s === 1'b1) && (d_s !== exp_d)) n_bad++;
        if ((oe_s === 1'b1) && (rw_s !== 1'b0)) n_order++;
    endtask

    initial begin
        ba.db_in = 8'h00; ba.load = 1'b0; ba.write_start = 1'b0;
        bb.db_in = 8'h00; bb.load = 1'b0; bb.write_start = 1'b0;
        step();
        step();
        rst_a = 1'b0;
        rst_b = 1'b0;

        // Reset state
        check("rst_data_out", 32'(ba.data_out), 32'h00);
        check("rst_oe",       32'(ba.data_oe), 32'd0);
        check("rst_rw",       32'(ba.rw), 32'd1);
        check("rst_strobe",   32'(ba.data_strobe), 32'd0);
        check("rst_busy",     32'(ba.busy), 32'd0);
        check("rst_done",     32'(ba.done), 32'd0);

        // Default write of 0xA5
        ba.db_in = 8'hA5; ba.load = 1'b1;
        step();
        ba.load = 1'b0;
        check("load_a5", 32'(ba.data_out), 32'hA5);
        clr_counts();
        ba.write_start = 1'b1;
        step();
        ba.write_start = 1'b0;
        check("k0_busy", 32'(ba.busy), 32'd1);
        check("k0_rw",   32'(ba.rw), 32'd0);
        check("k0_oe",   32'(ba.data_oe), 32'd0);
        sample(0, 8'hA5);
        for (int k = 1; k <= 5; k++) begin
            step();
            if (k == 1) check("k1_strobe", 32'({ba.data_oe, ba.data_strobe}), 32'b11);
            if (k == 4) check("k4_idle", 32'({ba.busy, ba.rw, ba.data_oe, ba.done}), 32'b0101);
            sample(0, 8'hA5);
        end
        check("w1_rw_low",  32'(n_rw), 32'd4);
        check("w1_oe",      32'(n_oe), 32'd3);
        check("w1_strobe",  32'(n_st), 32'd2);
        check("w1_done",    32'(n_done), 32'd1);
        check("w1_data",    32'(n_bad), 32'd0);
        check("w1_order",   32'(n_order), 32'd0);
        check("w1_rw_back", 32'(ba.rw), 32'd1);

        // Same-cycle load and write_start
        clr_counts();
        ba.db_in = 8'h3C; ba.load = 1'b1; ba.write_start = 1'b1;
        step();
        ba.load = 1'b0; ba.write_start = 1'b0; ba.db_in = 8'h00;
        sample(0, 8'h3C);
        for (int k = 1; k <= 5; k++) begin
            step();
            if (k == 1) check("w2_data_k1", 32'(ba.data_out), 32'h3C);
            sample(0, 8'h3C);
        end
        check("w2_data",  32'(n_bad), 32'd0);
        check("w2_oe",    32'(n_oe), 32'd3);
        check("w2_done",  32'(n_done), 32'd1);

        // Load during DRIVE goes to the shadow
        ba.db_in = 8'h22; ba.load = 1'b1;
        step();
        ba.load = 1'b0;
        ba.write_start = 1'b1;
        step();
        ba.write_start = 1'b0;
        step();
        ba.db_in = 8'h11; ba.load = 1'b1;
        step();
        ba.load = 1'b0; ba.db_in = 8'h00;
        check("w3_drive_data", 32'({ba.data_strobe, ba.data_out}), 32'h122);
        step();
        check("w3_hold_data", 32'({ba.data_oe, ba.data_strobe, ba.data_out}), 32'h222);
        step();
        check("w3_idle_dor", 32'({ba.done, ba.data_out}), 32'h111);
        clr_counts();
        ba.write_start = 1'b1;
        step();
        ba.write_start = 1'b0;
        sample(0, 8'h11);
        for (int k = 1; k <= 5; k++) begin
            step();
            sample(0, 8'h11);
        end
        check("w3b_data", 32'(n_bad), 32'd0);
        check("w3b_oe",   32'(n_oe), 32'd3);

        // write_start pulses during SETUP and HOLD are ignored
        clr_counts();
        begin
            logic [6:0] ws_pat;
            ws_pat = 7'b0010011;
            for (int k = 0; k <= 6; k++) begin
                ba.write_start = ws_pat[k];
                step();
                sample(0, 8'h11);
            end
        end
        ba.write_start = 1'b0;
        check("w4_busy", 32'(n_busy), 32'd4);
        check("w4_done", 32'(n_done), 32'd1);

        // Reset during DRIVE, with a pending shadow load
        ba.write_start = 1'b1;
        step();
        ba.write_start = 1'b0;
        step();
        check("w5_in_drive", 32'(ba.data_oe), 32'd1);
        ba.db_in = 8'h77; ba.load = 1'b1;
        step();
        ba.load = 1'b0;
        rst_a = 1'b1;
        step();
        check("w5_rst_outs", 32'({ba.data_oe, ba.rw, ba.data_strobe, ba.busy, ba.done}), 32'b01000);
        check("w5_rst_data", 32'(ba.data_out), 32'h00);
        rst_a = 1'b0;
        clr_counts();
        for (int k = 0; k < 3; k++) begin
            step();
            sample(0, 8'h00);
        end
        check("w5_no_done", 32'(n_done), 32'd0);
        check("w5_no_busy", 32'(n_busy), 32'd0);
        check("w5_shadow_gone", 32'(ba.data_out), 32'h00);

        // H=0 build: S=2, D=1
        clr_counts();
        bb.db_in = 8'h5A; bb.load = 1'b1; bb.write_start = 1'b1;
        step();
        bb.load = 1'b0; bb.write_start = 1'b0;
        sample(1, 8'h5A);
        for (int k = 1; k <= 4; k++) begin
            step();
            sample(1, 8'h5A);
        end
        check("b_oe",     32'(n_oe), 32'd1);
        check("b_strobe", 32'(n_st), 32'd1);
        check("b_busy",   32'(n_busy), 32'd3);
        check("b_rw_low", 32'(n_rw), 32'd3);
        check("b_done",   32'(n_done), 32'd1);
        check("b_data",   32'(n_bad), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
